cv_frame_gen: RTL and testbench

- Stimulus/frame source directly upstream of the rate-1/2 (7,5) convolutional encoder in the telemetry test path.
- On `start`, emits one frame as a serial bit stream on the encoder input interface (`enc_in_valid`/`enc_bit_in`). The frame is a PRBS7 payload followed by zero tail bits, which return the encoder to state 0. Extra zero flush bits follow, which drain the Viterbi traceback.
- `is_payload` tags payload bits for the downstream BER path.
- Reports `busy`, a one-cycle `done` pulse and a running frame count.

---
 rtl/cv_frame_gen_if.sv | 24 ++
 rtl/cv_frame_gen.sv | 154 +++++++++++++++
 tb/tb_cv_frame_gen.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv_frame_gen_if.sv
// Control and encoder-input bundle of the convolutional-encoder frame source.
// The master side is the generator; the slave side is the controller/encoder.
interface cv_frame_gen_if;
    logic        start;
    logic        abort;
    logic [6:0]  seed_in;
    logic        enc_in_valid;
    logic        enc_bit_in;
    logic        is_payload;
    logic [15:0] bit_idx;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    modport master (
        input  start, abort, seed_in,
        output enc_in_valid, enc_bit_in, is_payload, bit_idx, busy, done, frame_cnt
    );

    modport slave (
        output start, abort, seed_in,
        input  enc_in_valid, enc_bit_in, is_payload, bit_idx, busy, done, frame_cnt
    );
endinterface

// File: rtl/cv_frame_gen.sv
// Frame source for the rate-1/2 (7,5) encoder: PRBS7 payload, zero tail and
// zero flush bits, optional idle gap after each bit. All outputs registered.
module cv_frame_gen #(
    parameter int unsigned PAY_LEN   = 10,
    parameter int unsigned TAIL_LEN  = 2,
    parameter int unsigned FLUSH_LEN = 12,
    parameter int unsigned GAP       = 0,
    parameter logic [6:0]  DEF_SEED  = 7'h01
) (
    input  logic            clk,
    input  logic            enc_rst_n,
    cv_frame_gen_if.master  bus
);

    localparam logic [15:0] PAY_LEN16 = 16'(PAY_LEN);
    localparam logic [15:0] LAST_IDX  = 16'(PAY_LEN + TAIL_LEN + FLUSH_LEN - 1);
    localparam logic [7:0]  GAP_M1    = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_PAY, S_ZERO, S_GAP, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] bit_idx_q, bit_idx_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        valid_q, valid_d;
    logic        bit_q, bit_d;
    logic        pay_q, pay_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        emit;
    logic        finish;
    logic [15:0] emit_idx;
    logic [6:0]  emit_lfsr;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        gap_cnt_d   = gap_cnt_q;
        bit_idx_d   = bit_idx_q;
        frame_cnt_d = frame_cnt_q;
        valid_d     = 1'b0;
        bit_d       = 1'b0;
        pay_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        emit        = 1'b0;
        finish      = 1'b0;
        emit_idx    = bit_idx_q + 16'd1;
        emit_lfsr   = lfsr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    emit      = 1'b1;
                    emit_idx  = 16'd0;
                    emit_lfsr = (bus.seed_in == 7'd0) ? DEF_SEED : bus.seed_in;
                end
            end
            S_PAY, S_ZERO: begin
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = 8'd0;
                end else if (GAP != 0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_M1;
                    busy_d    = 1'b1;
                end else if (bit_idx_q == LAST_IDX) begin
                    finish = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = 8'd0;
                end else if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                    busy_d    = 1'b1;
                end else if (bit_idx_q == LAST_IDX) begin
                    finish = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Load the next bit; the section is chosen from its index in the frame.
        if (emit) begin
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            bit_idx_d = emit_idx;
            if (emit_idx < PAY_LEN16) begin
                state_d = S_PAY;
                pay_d   = 1'b1;
                bit_d   = emit_lfsr[6];
                lfsr_d  = {emit_lfsr[5:0], emit_lfsr[6] ^ emit_lfsr[5]};
            end else begin
                state_d = S_ZERO;
            end
        end

        if (finish) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge enc_rst_n) begin
        if (!enc_rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= DEF_SEED;
            gap_cnt_q   <= 8'd0;
            bit_idx_q   <= 16'd0;
            frame_cnt_q <= 16'd0;
            valid_q     <= 1'b0;
            bit_q       <= 1'b0;
            pay_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_idx_q   <= bit_idx_d;
            frame_cnt_q <= frame_cnt_d;
            valid_q     <= valid_d;
            bit_q       <= bit_d;
            pay_q       <= pay_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.enc_in_valid = valid_q;
    assign bus.enc_bit_in   = bit_q;
    assign bus.is_payload   = pay_q;
    assign bus.bit_idx      = bit_idx_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_cv_frame_gen.sv
// Directed bench for cv_frame_gen: default frame, gapped short frame, ignored
// start, abort, back-to-back frames and asynchronous reset.
module tb_cv_frame_gen;

    logic clk = 1'b0;
    logic enc_rst_n;
    int   errors = 0;
    int   checks = 0;

    cv_frame_gen_if bus ();
    cv_frame_gen_if bus_g ();

    cv_frame_gen dut (
        .clk       (clk),
        .enc_rst_n (enc_rst_n),
        .bus       (bus)
    );

    cv_frame_gen #(
        .PAY_LEN   (3),
        .TAIL_LEN  (0),
        .FLUSH_LEN (0),
        .GAP       (2),
        .DEF_SEED  (7'h01)
    ) dut_g (
        .clk       (clk),
        .enc_rst_n (enc_rst_n),
        .bus       (bus_g)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        enc_rst_n     = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.seed_in   = 7'd0;
        bus_g.start   = 1'b0;
        bus_g.abort   = 1'b0;
        bus_g.seed_in = 7'd0;
        @(negedge clk);
        @(negedge clk);
        enc_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.enc_in_valid, bus.enc_bit_in, bus.is_payload, bus.busy, bus.done,
             bus.bit_idx, bus.frame_cnt} !== 37'd0) begin
            errors++;
            $display("FAIL reset_main got v=%b b=%b p=%b busy=%b done=%b idx=%0d cnt=%0d exp all 0",
                     bus.enc_in_valid, bus.enc_bit_in, bus.is_payload, bus.busy, bus.done,
                     bus.bit_idx, bus.frame_cnt);
        end
        checks++;
        if ({bus_g.enc_in_valid, bus_g.enc_bit_in, bus_g.is_payload, bus_g.busy, bus_g.done,
             bus_g.bit_idx, bus_g.frame_cnt} !== 37'd0) begin
            errors++;
            $display("FAIL reset_gap got v=%b busy=%b done=%b idx=%0d cnt=%0d exp all 0",
                     bus_g.enc_in_valid, bus_g.busy, bus_g.done, bus_g.bit_idx, bus_g.frame_cnt);
        end
    endtask

    // Default seed 0x01: payload bits 0,0,0,0,0,0,1,0,0,0 then 14 zero bits.
    // Must be entered right after a reset so frame_cnt reads 1 at done.
    task automatic test_default_frame(input string tag);
        logic [9:0]  pat;
        logic [20:0] obs;
        logic [20:0] exp_o;
        logic        ev, eb, ep, ebusy, edone;
        logic [15:0] eidx;
        pat = 10'b00_0100_0000;
        @(negedge clk);
        bus.seed_in = 7'd0;
        bus.start   = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            ev    = (c <= 24);
            eb    = (c <= 10) ? pat[c-1] : 1'b0;
            ep    = (c <= 10);
            ebusy = (c <= 24);
            edone = (c == 25);
            eidx  = (c <= 24) ? 16'(c - 1) : 16'd23;
            exp_o = {ev, eb, ep, ebusy, edone, eidx};
            obs   = {bus.enc_in_valid, bus.enc_bit_in, bus.is_payload, bus.busy, bus.done, bus.bit_idx};
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL %s cyc=%0d got v,b,p,busy,done=%b idx=%0d exp %b idx=%0d",
                         tag, c, obs[20:16], obs[15:0], exp_o[20:16], exp_o[15:0]);
            end
            if (c == 25) begin
                checks++;
                if (bus.frame_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL %s frame_cnt got=%0d exp=1", tag, bus.frame_cnt);
                end
            end
        end
    endtask

    // PAY_LEN=3, GAP=2, seed 0x60: LFSR 1100000 -> 1000000 -> 0000001, bits 1,1,0.
    task automatic test_gap();
        logic [20:0] obs;
        logic [20:0] exp_o;
        logic        ev, eb, ebusy, edone;
        logic [15:0] eidx;
        do_reset();
        bus_g.seed_in = 7'h60;
        bus_g.start   = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus_g.start = 1'b0;
            ev    = (c == 1) || (c == 4) || (c == 7);
            eb    = ev && (c != 7);
            ebusy = (c <= 9);
            edone = (c == 10);
            eidx  = (c <= 9) ? 16'((c - 1) / 3) : 16'd2;
            exp_o = {ev, eb, ev, ebusy, edone, eidx};
            obs   = {bus_g.enc_in_valid, bus_g.enc_bit_in, bus_g.is_payload, bus_g.busy,
                     bus_g.done, bus_g.bit_idx};
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL gap cyc=%0d got v,b,p,busy,done=%b idx=%0d exp %b idx=%0d",
                         c, obs[20:16], obs[15:0], exp_o[20:16], exp_o[15:0]);
            end
        end
        checks++;
        if (bus_g.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL gap_frame_cnt got=%0d exp=1", bus_g.frame_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int nvalid = 0;
        int ndone  = 0;
        do_reset();
        bus.seed_in = 7'd0;
        bus.start   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.enc_in_valid) nvalid++;
            if (bus.done) ndone++;
            // Pulse start mid-frame (bit 5) and again during the done cycle.
            bus.start = (bus.enc_in_valid && bus.bit_idx == 16'd5) || bus.done;
        end
        bus.start = 1'b0;
        checks++;
        if (nvalid != 24) begin
            errors++;
            $display("FAIL ignore_bits got=%0d exp=24", nvalid);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL ignore_done got=%0d exp=1", ndone);
        end
        checks++;
        if (bus.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ignore_frame_cnt got=%0d exp=1", bus.frame_cnt);
        end
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        int ndone = 0;
        do_reset();
        bus.seed_in = 7'd0;
        bus.start   = 1'b1;
        for (int c = 1; c <= 30 && !found; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.enc_in_valid && bus.bit_idx == 16'd12) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_idx12 got=timeout exp=bit_idx 12 within 30 cycles");
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if ({bus.enc_in_valid, bus.is_payload, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL abort_outputs got v,p,busy=%b exp 000",
                     {bus.enc_in_valid, bus.is_payload, bus.busy});
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        checks++;
        if (ndone != 0 || bus.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL abort_no_done got done=%0d cnt=%0d exp done=0 cnt=0", ndone, bus.frame_cnt);
        end
        // Start and abort together in IDLE: nothing starts.
        bus.seed_in = 7'h60;
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if ({bus.enc_in_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL start_abort_idle got v,busy=%b exp 00", {bus.enc_in_valid, bus.busy});
        end
        // Restart with seed 0x60; the seed is changed after acceptance and must not matter.
        bus.start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.seed_in = 7'h00;
            checks++;
            if ({bus.enc_in_valid, bus.enc_bit_in, bus.is_payload, bus.bit_idx} !==
                {1'b1, (c != 3), 1'b1, 16'(c - 1)}) begin
                errors++;
                $display("FAIL restart cyc=%0d got v=%b b=%b p=%b idx=%0d exp v=1 b=%0d p=1 idx=%0d",
                         c, bus.enc_in_valid, bus.enc_bit_in, bus.is_payload, bus.bit_idx,
                         (c != 3), c - 1);
            end
        end
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (bus.done) found = 1'b1;
        end
        checks++;
        if (!found || bus.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL restart_done got done_seen=%0d cnt=%0d exp 1 and 1", found, bus.frame_cnt);
        end
    endtask

    // start held: bits 1..24, done 25, idle 26, bits 27..50, done 51, idle 52, bits from 53.
    task automatic test_back_to_back();
        int nvalid = 0;
        int ndone  = 0;
        do_reset();
        bus.seed_in = 7'd0;
        bus.start   = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.enc_in_valid) nvalid++;
            if (bus.done) ndone++;
            if (c == 25 || c == 51) begin
                checks++;
                if (bus.done !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_done cyc=%0d got=%b exp=1", c, bus.done);
                end
            end
            if (c == 26 || c == 52) begin
                checks++;
                if ({bus.enc_in_valid, bus.busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_idle cyc=%0d got v,busy=%b exp 00", c, {bus.enc_in_valid, bus.busy});
                end
            end
            if (c == 27 || c == 53) begin
                checks++;
                if ({bus.enc_in_valid, bus.bit_idx} !== {1'b1, 16'd0}) begin
                    errors++;
                    $display("FAIL b2b_first cyc=%0d got v=%b idx=%0d exp v=1 idx=0",
                             c, bus.enc_in_valid, bus.bit_idx);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (nvalid != 56 || ndone != 2) begin
            errors++;
            $display("FAIL b2b_counts got bits=%0d done=%0d exp bits=56 done=2", nvalid, ndone);
        end
        checks++;
        if (bus.frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL b2b_frame_cnt got=%0d exp=2", bus.frame_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        test_default_frame("pre_reset_frame");
        bus.seed_in = 7'h33;
        bus.start   = 1'b1;
        repeat (8) @(negedge clk);
        bus.start = 1'b0;
        #2 enc_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.enc_in_valid, bus.enc_bit_in, bus.is_payload, bus.busy, bus.done,
             bus.bit_idx, bus.frame_cnt} !== 37'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b busy=%b idx=%0d cnt=%0d exp all 0",
                     bus.enc_in_valid, bus.busy, bus.bit_idx, bus.frame_cnt);
        end
        @(negedge clk);
        enc_rst_n = 1'b1;
        test_default_frame("post_reset_frame");
    endtask

    initial begin
        test_reset();
        do_reset();
        test_default_frame("default_frame");
        test_gap();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
